// File: rtl/wr_mux_rr_pkg.sv
// Shared types and helpers for the round-robin write-request multiplexer.
package wr_mux_rr_pkg;

  localparam int unsigned DW = 64;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Channel index width; at least one bit so NCH=1 still has a legal vector.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/wr_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping, one-hot result.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_mux_rr.sv
// N-channel burst-granular round-robin write mux with registered output slice,
// per-burst beat counting and a sticky length-error flag.
import wr_mux_rr_pkg::*;

module wr_mux_rr #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned AMIN      = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    wri_valid,
  output logic [NCH-1:0]    wri_ready,
  input  logic [NCH-1:0]    wri_last,
  input  logic [NCH*DW-1:0] wri_addr,
  input  logic [NCH*DW-1:0] wri_data,
  output logic              wro_valid,
  input  logic              wro_ready,
  output logic [DW-1:0]     wro_addr,
  output logic [DW-1:0]     wro_data,
  output logic              wro_last,
  output logic [2:0]        wro_chan,
  output logic              err_len
);

  localparam int unsigned CW    = chan_w(NCH);
  localparam logic [6:0]  BL    = 7'(BURST_LEN);
  localparam logic [63:0] AMASK = ~((64'd1 << AMIN) - 64'd1);

  state_t        state, state_n;
  logic [CW-1:0] gnt, ptr, arb_idx;
  logic [NCH-1:0] arb_oh;
  logic [6:0]    cnt, cnt_inc;
  logic [DW-1:0] sel_addr, sel_data;
  logic          accept, sel_last, beat_last, len_bad;

  rr_arbiter #(.N(NCH), .W(CW)) u_arb (
    .req (wri_valid),
    .ptr (ptr),
    .gnt (arb_oh)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (arb_oh[i]) arb_idx = CW'(i);
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt == CW'(i)) begin
        sel_addr = wri_addr[DW*i +: DW];
        sel_data = wri_data[DW*i +: DW];
      end
    end
  end

  // Ready is gated by reset_n so nothing is accepted in a synchronous reset cycle.
  always_comb begin
    wri_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wri_ready[i] = reset_n && (state == S_BURST) && (gnt == CW'(i)) &&
                     (!wro_valid || wro_ready);
    end
  end

  // wri_ready is one-hot on the granted channel, so masking selects its last bit.
  always_comb begin
    cnt_inc   = cnt + 7'd1;
    accept    = |(wri_valid & wri_ready);
    sel_last  = |(wri_last & wri_ready);
    beat_last = sel_last || (cnt_inc == BL);
    len_bad   = sel_last != (cnt_inc == BL);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (|wri_valid) state_n = S_BURST;
      S_BURST: if (accept && beat_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      ptr       <= CW'(NCH - 1);
      cnt       <= '0;
      wro_valid <= 1'b0;
      wro_addr  <= '0;
      wro_data  <= '0;
      wro_last  <= 1'b0;
      wro_chan  <= '0;
      err_len   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && |wri_valid) begin
        gnt <= arb_idx;
        ptr <= arb_idx;
        cnt <= '0;
      end
      if (accept) begin
        wro_valid <= 1'b1;
        wro_data  <= sel_data;
        wro_last  <= beat_last;
        cnt       <= cnt_inc;
        if (cnt == '0) begin
          wro_addr <= sel_addr & AMASK;
          wro_chan <= 3'(gnt);
        end
        if (len_bad) err_len <= 1'b1;
      end else if (wro_ready) begin
        wro_valid <= 1'b0;
      end
    end
  end

endmodule
